cachable_regions: RTL and testbench



---
 rtl/cachable_regions_if.sv | 38 +++
 rtl/cachable_regions.sv | 111 +++++++++++
 tb/tb_cachable_regions.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cachable_regions_if.sv
// rtl/cachable_regions_if.sv - control-slave and lookup signal bundle for cachable_regions
interface cachable_regions_if #(
  parameter int AW   = 28,
  parameter int LGNR = 2
);
  logic            i_wb_cyc;
  logic            i_wb_stb;
  logic            i_wb_we;
  logic [LGNR:0]   i_wb_addr;
  logic [31:0]     i_wb_data;
  logic [3:0]      i_wb_sel;
  logic            o_wb_stall;
  logic            o_wb_ack;
  logic [31:0]     o_wb_data;

  logic            i_lk_valid;
  logic            o_lk_ready;
  logic [AW-1:0]   i_lk_addr;
  logic            o_lk_valid;
  logic            i_lk_ready;
  logic            o_lk_cachable;
  logic [LGNR-1:0] o_lk_region;
  logic            o_flush;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    input  o_wb_stall, o_wb_ack, o_wb_data,
    output i_lk_valid, i_lk_addr, i_lk_ready,
    input  o_lk_ready, o_lk_valid, o_lk_cachable, o_lk_region, o_flush
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data, i_wb_sel,
    output o_wb_stall, o_wb_ack, o_wb_data,
    input  i_lk_valid, i_lk_addr, i_lk_ready,
    output o_lk_ready, o_lk_valid, o_lk_cachable, o_lk_region, o_flush
  );
endinterface

// File: rtl/cachable_regions.sv
// rtl/cachable_regions.sv - programmable base/mask cachability table; CACHABLE_READBACK_EN enables register readback
module cachable_regions #(
  parameter int            ADDRESS_WIDTH = 28,
  parameter int            NREGIONS      = 4,
  parameter int            LGNR          = (NREGIONS > 1) ? $clog2(NREGIONS) : 1,
  parameter logic [ADDRESS_WIDTH-1:0] MEM_ADDR = {2'b01, {(ADDRESS_WIDTH-2){1'b0}}},
  parameter logic [ADDRESS_WIDTH-1:0] MEM_MASK = {2'b11, {(ADDRESS_WIDTH-2){1'b0}}}
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  cachable_regions_if.slave  bus
);
  localparam int AW = ADDRESS_WIDTH;

  logic [AW-1:0]   base [NREGIONS];
  logic [AW-1:0]   mask [NREGIONS];

  logic [LGNR-1:0] widx;
  logic            wsel_mask;
  logic            wr_en;
  logic [AW-1:0]   lane_mask;
  logic [AW-1:0]   cur_val;
  logic [AW-1:0]   new_val;

  logic            hit;
  logic [LGNR-1:0] hit_idx;
  logic            lk_xfer;

  assign widx      = bus.i_wb_addr[LGNR:1];
  assign wsel_mask = bus.i_wb_addr[0];
  assign wr_en     = bus.i_wb_stb && bus.i_wb_we && (|bus.i_wb_sel);

  for (genvar k = 0; k < AW; k++) begin : g_lane
    assign lane_mask[k] = bus.i_wb_sel[k/8];
  end

  assign cur_val = wsel_mask ? mask[widx] : base[widx];
  assign new_val = (cur_val & ~lane_mask) | (bus.i_wb_data[AW-1:0] & lane_mask);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int r = 0; r < NREGIONS; r++) begin
        base[r] <= '0;
        mask[r] <= '0;
      end
      base[0] <= MEM_ADDR;
      mask[0] <= MEM_MASK;
    end else if (wr_en) begin
      if (wsel_mask)
        mask[widx] <= new_val;
      else
        base[widx] <= new_val;
    end
  end

  // Ack follows cyc so an abandoned burst never sees a stray ack afterwards.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus.o_wb_ack <= 1'b0;
      bus.o_flush  <= 1'b0;
    end else begin
      bus.o_wb_ack <= bus.i_wb_cyc && bus.i_wb_stb;
      bus.o_flush  <= wr_en;
    end
  end

  assign bus.o_wb_stall = 1'b0;

`ifdef CACHABLE_READBACK_EN
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)
      bus.o_wb_data <= '0;
    else if (bus.i_wb_stb)
      bus.o_wb_data <= 32'(wsel_mask ? mask[widx] : base[widx]);
  end
`else
  assign bus.o_wb_data = '0;
`endif

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int r = NREGIONS - 1; r >= 0; r--) begin
      if ((base[r] != '0) && ((bus.i_lk_addr & mask[r]) == base[r])) begin
        hit     = 1'b1;
        hit_idx = LGNR'(r);
      end
    end
  end

  assign bus.o_lk_ready = !bus.o_lk_valid || bus.i_lk_ready;
  assign lk_xfer        = bus.i_lk_valid && bus.o_lk_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      bus.o_lk_valid    <= 1'b0;
      bus.o_lk_cachable <= 1'b0;
      bus.o_lk_region   <= '0;
    end else if (lk_xfer) begin
      bus.o_lk_valid    <= 1'b1;
      bus.o_lk_cachable <= hit;
      bus.o_lk_region   <= hit_idx;
    end else if (bus.i_lk_ready) begin
      bus.o_lk_valid    <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, bus.i_wb_data};
endmodule

// File: tb/tb_cachable_regions.sv
// tb/tb_cachable_regions.sv - directed scoreboard bench for cachable_regions
module tb_cachable_regions;
  localparam int AW   = 28;
  localparam int NR   = 4;
  localparam int LGNR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [LGNR:0] exp_q[$];

  cachable_regions_if #(.AW(AW), .LGNR(LGNR)) bus ();

  cachable_regions #(.ADDRESS_WIDTH(AW), .NREGIONS(NR), .LGNR(LGNR)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LGNR:0] res(input logic c, input logic [LGNR-1:0] r);
    return {c, r};
  endfunction

  task automatic pop_chk(input string tag);
    logic [LGNR:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_valid"}, 32'(bus.o_lk_valid), 32'd1);
      chk({tag, "_cach"}, 32'(bus.o_lk_cachable), 32'(e[LGNR]));
      chk({tag, "_region"}, 32'(bus.o_lk_region), 32'(e[LGNR-1:0]));
    end
  endtask

  task automatic lookup(input string tag, input logic [AW-1:0] a, input logic c, input logic [LGNR-1:0] r);
    chk({tag, "_rdy"}, 32'(bus.o_lk_ready), 32'd1);
    bus.i_lk_valid = 1'b1;
    bus.i_lk_addr  = a;
    exp_q.push_back(res(c, r));
    tick();
    bus.i_lk_valid = 1'b0;
    pop_chk(tag);
    tick();
    chk({tag, "_clr"}, 32'(bus.o_lk_valid), 32'd0);
  endtask

  task automatic wb_write(input string tag, input logic [LGNR:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b1;
    bus.i_wb_addr = a;
    bus.i_wb_data = d;
    bus.i_wb_sel  = s;
    tick();
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    bus.i_wb_we  = 1'b0;
    chk({tag, "_ack"}, 32'(bus.o_wb_ack), 32'd1);
    chk({tag, "_flush"}, 32'(bus.o_flush), 32'(|s));
    tick();
    chk({tag, "_ack0"}, 32'(bus.o_wb_ack), 32'd0);
    chk({tag, "_flush0"}, 32'(bus.o_flush), 32'd0);
  endtask

  task automatic wb_read(input string tag, input logic [LGNR:0] a, input logic [31:0] stored);
    logic [31:0] e;
`ifdef CACHABLE_READBACK_EN
    e = stored;
`else
    e = 32'd0;
`endif
    bus.i_wb_cyc  = 1'b1;
    bus.i_wb_stb  = 1'b1;
    bus.i_wb_we   = 1'b0;
    bus.i_wb_addr = a;
    tick();
    bus.i_wb_cyc = 1'b0;
    bus.i_wb_stb = 1'b0;
    chk({tag, "_ack"}, 32'(bus.o_wb_ack), 32'd1);
    chk({tag, "_data"}, bus.o_wb_data, e);
    chk({tag, "_noflush"}, 32'(bus.o_flush), 32'd0);
    tick();
  endtask

  initial begin
    logic [AW-1:0] addrs [4];
    logic          ecach [4];
    logic [LGNR-1:0] ereg [4];

    bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0;
    bus.i_wb_addr = '0; bus.i_wb_data = '0; bus.i_wb_sel = '0;
    bus.i_lk_valid = 0; bus.i_lk_addr = '0; bus.i_lk_ready = 1;

    tick(); tick();
    chk("rst_valid", 32'(bus.o_lk_valid), 32'd0);
    chk("rst_cach", 32'(bus.o_lk_cachable), 32'd0);
    chk("rst_region", 32'(bus.o_lk_region), 32'd0);
    chk("rst_ack", 32'(bus.o_wb_ack), 32'd0);
    chk("rst_flush", 32'(bus.o_flush), 32'd0);
    chk("rst_data", bus.o_wb_data, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("stall", 32'(bus.o_wb_stall), 32'd0);

    lookup("lk_mem", 28'h4001234, 1'b1, 2'd0);
    lookup("lk_miss", 28'h1000000, 1'b0, 2'd0);

    // back-to-back strobes programming region 1
    bus.i_wb_cyc = 1; bus.i_wb_stb = 1; bus.i_wb_we = 1; bus.i_wb_sel = 4'hF;
    bus.i_wb_addr = 3'd2; bus.i_wb_data = 32'h1000000;
    tick();
    chk("burst_ack1", 32'(bus.o_wb_ack), 32'd1);
    chk("burst_flush1", 32'(bus.o_flush), 32'd1);
    bus.i_wb_addr = 3'd3; bus.i_wb_data = 32'h0F000000;
    tick();
    chk("burst_ack2", 32'(bus.o_wb_ack), 32'd1);
    chk("burst_flush2", 32'(bus.o_flush), 32'd1);
    bus.i_wb_cyc = 0; bus.i_wb_stb = 0; bus.i_wb_we = 0;
    tick();
    chk("burst_ack_end", 32'(bus.o_wb_ack), 32'd0);
    chk("burst_flush_end", 32'(bus.o_flush), 32'd0);

    lookup("lk_r1", 28'h1000040, 1'b1, 2'd1);

    // one lookup per cycle
    addrs[0] = 28'h1000040; ecach[0] = 1; ereg[0] = 1;
    addrs[1] = 28'h4000004; ecach[1] = 1; ereg[1] = 0;
    addrs[2] = 28'h2000000; ecach[2] = 0; ereg[2] = 0;
    addrs[3] = 28'h1FFFFFF; ecach[3] = 1; ereg[3] = 1;
    for (int i = 0; i < 4; i++) begin
      bus.i_lk_valid = 1'b1;
      bus.i_lk_addr  = addrs[i];
      exp_q.push_back(res(ecach[i], ereg[i]));
      tick();
      pop_chk($sformatf("pipe%0d", i));
    end
    bus.i_lk_valid = 1'b0;
    tick();

    wb_write("ovl_base1", 3'd2, 32'h4000000, 4'hF);
    lookup("lk_prio", 28'h4000010, 1'b1, 2'd0);
    wb_write("clr_base0", 3'd0, 32'h0, 4'hF);
    lookup("lk_r1b", 28'h4000010, 1'b1, 2'd1);

    // backpressure
    bus.i_lk_ready = 1'b0;
    bus.i_lk_valid = 1'b1;
    bus.i_lk_addr  = 28'h4000010;
    exp_q.push_back(res(1'b1, 2'd1));
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.i_lk_addr = 28'h1000000 + AW'(i);
      chk($sformatf("bp%0d_rdy", i), 32'(bus.o_lk_ready), 32'd0);
      chk($sformatf("bp%0d_valid", i), 32'(bus.o_lk_valid), 32'd1);
      chk($sformatf("bp%0d_cach", i), 32'(bus.o_lk_cachable), 32'(exp_q[0][LGNR]));
      chk($sformatf("bp%0d_region", i), 32'(bus.o_lk_region), 32'(exp_q[0][LGNR-1:0]));
      tick();
    end
    bus.i_lk_ready = 1'b1;
    bus.i_lk_addr  = 28'h2000000;
    pop_chk("bp_held");
    exp_q.push_back(res(1'b0, 2'd0));
    tick();
    bus.i_lk_valid = 1'b0;
    pop_chk("bp_next");
    tick();
    chk("bp_clr", 32'(bus.o_lk_valid), 32'd0);

    wb_write("part_base2", 3'd4, 32'hFFFFFFFF, 4'b0001);
    wb_read("rd_base2", 3'd4, 32'h000000FF);
    wb_write("sel0", 3'd5, 32'hFFFFFFFF, 4'b0000);
    wb_read("rd_mask2", 3'd5, 32'h0);
    wb_write("hi_bits", 3'd6, 32'hFFFFFFFF, 4'hF);
    wb_read("rd_base3", 3'd6, 32'h0FFFFFFF);

    // reprogram, then reset with a held result
    wb_write("re_base1", 3'd2, 32'h1000000, 4'hF);
    bus.i_lk_ready = 1'b0;
    bus.i_lk_valid = 1'b1;
    bus.i_lk_addr  = 28'h1000040;
    exp_q.push_back(res(1'b1, 2'd1));
    tick();
    bus.i_lk_valid = 1'b0;
    pop_chk("pre_rst");
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", 32'(bus.o_lk_valid), 32'd0);
    chk("mid_rst_flush", 32'(bus.o_flush), 32'd0);
    rst_n = 1'b1;
    bus.i_lk_ready = 1'b1;
    tick();
    chk("post_rst_flush", 32'(bus.o_flush), 32'd0);
    lookup("post_rst_r1", 28'h1000040, 1'b0, 2'd0);
    lookup("post_rst_r0", 28'h4000010, 1'b1, 2'd0);
    wb_read("post_rd_base1", 3'd2, 32'h0);
    wb_read("post_rd_base0", 3'd0, 32'h4000000);
    wb_read("post_rd_mask0", 3'd1, 32'hC000000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
